// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - eight-digit multiplexed seven-segment scanner with per-frame snapshot
module hex_display_scanner #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic [31:0] HexDisplay32Bits,
   input  logic        Display_Freeze,
   input  logic        Blank_Leading_Zeros,
   output logic [7:0]  Digit_Select,
   output logic [6:0]  Segments,
   output logic        Display_Changed
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);

   logic [CW-1:0] scan_cnt;
   logic [2:0]    digit_idx;
   logic [31:0]   snapshot;

   logic          slot_tick;
   logic          capture;
   logic          blanked;
   logic          suppressed;
   logic [3:0]    nibble;
   logic [7:0]    zero_from;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      s = 7'h7F;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_tick = (scan_cnt == LAST_CNT);
      capture   = slot_tick && (digit_idx == 3'd7);
      blanked   = 32'(scan_cnt) < BLANK_CYCLES;
      nibble    = snapshot[{digit_idx, 2'b00} +: 4];
      // zero_from[i]: nibbles i..7 of the snapshot are all zero
      zero_from = '0;
      for (int i = 0; i < 8; i++) begin
         zero_from[i] = ~|(snapshot >> (4 * i));
      end
      suppressed = Blank_Leading_Zeros && (digit_idx != 3'd0) && zero_from[digit_idx];
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         scan_cnt        <= '0;
         digit_idx       <= 3'd0;
         snapshot        <= 32'h0;
         Digit_Select    <= 8'hFF;
         Segments        <= 7'h7F;
         Display_Changed <= 1'b0;
      end else begin
         scan_cnt <= slot_tick ? '0 : scan_cnt + CW'(1);
         if (slot_tick) begin
            digit_idx <= digit_idx + 3'd1;
         end

         Display_Changed <= 1'b0;
         if (capture && !Display_Freeze) begin
            snapshot        <= HexDisplay32Bits;
            Display_Changed <= (HexDisplay32Bits != snapshot);
         end

         Digit_Select <= blanked ? 8'hFF : ~(8'h01 << digit_idx);
         Segments     <= (blanked || suppressed) ? 7'h7F : hex_to_seg(nibble);
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed self-checking bench for hex_display_scanner
module tb_hex_display_scanner;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic [31:0] HexDisplay32Bits;
   logic        Display_Freeze;
   logic        Blank_Leading_Zeros;
   logic [7:0]  Digit_Select;
   logic [6:0]  Segments;
   logic        Display_Changed;
   logic [7:0]  ds0;
   logic [6:0]  seg0;
   logic        chg0;

   int n_vec = 0;
   int n_bad = 0;

   hex_display_scanner #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
      .Clock               (Clock),
      .Resetn              (Resetn),
      .HexDisplay32Bits    (HexDisplay32Bits),
      .Display_Freeze      (Display_Freeze),
      .Blank_Leading_Zeros (Blank_Leading_Zeros),
      .Digit_Select        (Digit_Select),
      .Segments            (Segments),
      .Display_Changed     (Display_Changed)
   );

   hex_display_scanner #(.SCAN_DIV(4), .BLANK_CYCLES(0)) dut0 (
      .Clock               (Clock),
      .Resetn              (Resetn),
      .HexDisplay32Bits    (HexDisplay32Bits),
      .Display_Freeze      (Display_Freeze),
      .Blank_Leading_Zeros (Blank_Leading_Zeros),
      .Digit_Select        (ds0),
      .Segments            (seg0),
      .Display_Changed     (chg0)
   );

   always #5 Clock = ~Clock;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Starts just after a capture edge, ends on the next capture edge.
   // exp holds the per-digit segments {d7,...,d0}; tog wiggles the input every clock.
   task automatic run_frame(input string tag, input logic [55:0] exp, input bit tog,
                            input logic [31:0] va, input logic [31:0] vb);
      for (int d = 0; d < 8; d++) begin
         for (int c = 0; c < 4; c++) begin
            int i;
            logic [7:0] en;
            i  = d * 4 + c;
            en = ~(8'h01 << d);
            if (tog) HexDisplay32Bits = i[0] ? vb : va;
            tick();
            if (c == 0) begin
               expect_eq($sformatf("%s_d%0d_blank_ds", tag, d), 32'(Digit_Select), 32'hFF);
               expect_eq($sformatf("%s_d%0d_blank_seg", tag, d), 32'(Segments), 32'h7F);
            end else begin
               expect_eq($sformatf("%s_d%0d_c%0d_ds", tag, d, c), 32'(Digit_Select), 32'(en));
               expect_eq($sformatf("%s_d%0d_c%0d_seg", tag, d, c), 32'(Segments), 32'(exp[7*d +: 7]));
            end
            expect_eq($sformatf("%s_d%0d_c%0d_ds0", tag, d, c), 32'(ds0), 32'(en));
            expect_eq($sformatf("%s_d%0d_c%0d_seg0", tag, d, c), 32'(seg0), 32'(exp[7*d +: 7]));
            if (i != 31) expect_eq($sformatf("%s_i%0d_chg", tag, i), 32'(Display_Changed), 32'h0);
         end
      end
   endtask

   localparam logic [55:0] S_1234ABCD = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
   localparam logic [55:0] S_A0_BLZ   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40};
   localparam logic [55:0] S_0_BLZ    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [55:0] S_1_BLZ    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79};
   localparam logic [55:0] S_2        = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h24};
   localparam logic [55:0] S_76543210 = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
   localparam logic [55:0] S_FEDCBA98 = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

   initial begin
      Resetn              = 1'b0;
      HexDisplay32Bits    = 32'h0;
      Display_Freeze      = 1'b0;
      Blank_Leading_Zeros = 1'b0;
      repeat (3) tick();
      expect_eq("rst_ds", 32'(Digit_Select), 32'hFF);
      expect_eq("rst_seg", 32'(Segments), 32'h7F);
      expect_eq("rst_chg", 32'(Display_Changed), 32'h0);

      @(negedge Clock) Resetn = 1'b1;
      repeat (6) tick();
      expect_eq("pre_rst_ds", 32'(Digit_Select), 32'hFD);
      expect_eq("pre_rst_seg", 32'(Segments), 32'h40);
      Resetn = 1'b0;
      #1;
      expect_eq("async_rst_ds", 32'(Digit_Select), 32'hFF);
      expect_eq("async_rst_seg", 32'(Segments), 32'h7F);
      expect_eq("async_rst_chg", 32'(Display_Changed), 32'h0);
      expect_eq("async_rst_ds0", 32'(ds0), 32'hFF);

      @(negedge Clock);
      Resetn           = 1'b1;
      HexDisplay32Bits = 32'h1234ABCD;
      tick();
      expect_eq("rel_e1_ds", 32'(Digit_Select), 32'hFF);
      expect_eq("rel_e1_seg", 32'(Segments), 32'h7F);
      tick();
      expect_eq("rel_e2_ds", 32'(Digit_Select), 32'hFE);
      expect_eq("rel_e2_seg", 32'(Segments), 32'h40);
      repeat (29) tick();
      expect_eq("pre_cap_chg", 32'(Display_Changed), 32'h0);
      tick();
      expect_eq("cap1_chg", 32'(Display_Changed), 32'h1);

      run_frame("f1", S_1234ABCD, 1'b0, 32'h0, 32'h0);
      expect_eq("f1_end_chg", 32'(Display_Changed), 32'h0);

      HexDisplay32Bits    = 32'h000000A0;
      Blank_Leading_Zeros = 1'b1;
      run_frame("f2", S_1234ABCD, 1'b0, 32'h0, 32'h0);
      expect_eq("f2_end_chg", 32'(Display_Changed), 32'h1);

      HexDisplay32Bits = 32'h0;
      run_frame("f3", S_A0_BLZ, 1'b0, 32'h0, 32'h0);
      expect_eq("f3_end_chg", 32'(Display_Changed), 32'h1);

      HexDisplay32Bits = 32'h1;
      run_frame("f4", S_0_BLZ, 1'b0, 32'h0, 32'h0);
      expect_eq("f4_end_chg", 32'(Display_Changed), 32'h1);

      Display_Freeze   = 1'b1;
      HexDisplay32Bits = 32'h2;
      run_frame("f5", S_1_BLZ, 1'b0, 32'h0, 32'h0);
      expect_eq("f5_frz_chg", 32'(Display_Changed), 32'h0);
      run_frame("f6", S_1_BLZ, 1'b0, 32'h0, 32'h0);
      expect_eq("f6_frz_chg", 32'(Display_Changed), 32'h0);

      Display_Freeze = 1'b0;
      run_frame("f7", S_1_BLZ, 1'b0, 32'h0, 32'h0);
      expect_eq("f7_unfrz_chg", 32'(Display_Changed), 32'h1);

      Blank_Leading_Zeros = 1'b0;
      run_frame("f8", S_2, 1'b1, 32'h89ABCDEF, 32'h76543210);
      expect_eq("f8_end_chg", 32'(Display_Changed), 32'h1);
      run_frame("f9", S_76543210, 1'b1, 32'h0F0F0F0F, 32'hFEDCBA98);
      expect_eq("f9_end_chg", 32'(Display_Changed), 32'h1);
      run_frame("f10", S_FEDCBA98, 1'b0, 32'h0, 32'h0);
      expect_eq("f10_end_chg", 32'(Display_Changed), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
